ps_eye_scan_ctrl: RTL and testbench
===================================

Name: ps_eye_scan_ctrl

Overview:
Parametrised successor of the SRU MMCM dynamic-phase-shift controller. It runs two kinds of phase move on psclk:
- Manual: N steps in a chosen direction.
- Auto eye-scan: walks the phase across a programmable range, qualifies each position against the deserialiser training pattern, finds the widest contiguous good window, then returns to its centre.
It sits between slow control and the MMCM PSEN/PSINCDEC/PSDONE port, next to the DTC deserialiser.

Parameters:
DW, 16, deserialiser word width
PATTERN, 16'hBC50, training word that marks a good sample (DW bits)
STEP_W, 16, width of step counters and position outputs
SETTLE_CYC, 8, psclk cycles to wait after psdone before sampling
SAMPLES, 4, consecutive matching words required for a good position
TIMEOUT_CYC, 1024, max psclk cycles to wait for psdone

Ports:
psclk  in  1  clock
reset  in  1  synchronous active-high reset
pscmd  in  1  command strobe; the command launches when pscmd deasserts after being seen high
psmode  in  1  0 = manual move, 1 = auto eye-scan
psdir  in  1  manual direction, 1 = increment
psstep  in  STEP_W  manual step count
scan_steps  in  STEP_W  number of positions evaluated in a scan
psen  out  1  MMCM phase-shift enable, one-cycle pulse
psincdec  out  1  MMCM direction, stable while psen is high
psdone  in  1  MMCM phase-shift done
deser_dout  in  DW  deserialised training data
psscan_flag  out  1  busy, high whenever state != IDLE
scan_done  out  1  one-cycle pulse when any command finishes (normal or timeout)
scan_ok  out  1  last auto scan found an eye
ps_timeout  out  1  sticky; cleared at the next command launch
phase_pos  out  STEP_W  current position, +1 per inc step, -1 per dec step, wraps mod 2^STEP_W
eye_start  out  STEP_W  first position of the widest good window
eye_width  out  STEP_W  length of the widest good window

Behaviour:
- Reset: all outputs 0, all counters 0, state = IDLE. A reset mid-operation aborts immediately with psen = 0. The MMCM phase itself is not restored; software must reset the MMCM as well.
- IDLE:
  - pscmd = 1 -> ARM.
  - ARM holds while pscmd = 1. On pscmd = 0, psmode, psdir, psstep and scan_steps are latched and ps_timeout is cleared.
  - From ARM, go to MAN_EN (manual) or SC_SETTLE (auto). Auto launch also clears phase_pos, eye_start, eye_width, run registers and scan_ok.
  - pscmd is ignored while busy.
- Step primitive (EN -> WAIT):
  - EN: psen = 1 for exactly one cycle; psincdec = direction; phase_pos updated in the same cycle.
  - WAIT: waits for psdone. psdone outside WAIT is ignored.
  - If TIMEOUT_CYC elapse without psdone: set ps_timeout, pulse scan_done, return to IDLE.
- Manual:
  - psstep = 0 -> no psen pulse; scan_done pulses on the cycle after launch.
  - Otherwise exactly psstep steps, then scan_done.
- Auto scan, position index k = 0..scan_steps-1:
  - SC_SETTLE: count SETTLE_CYC cycles.
  - SC_SAMPLE: compare deser_dout with PATTERN for SAMPLES consecutive cycles. Good only if all match; sampling ends early on the first mismatch.
  - SC_EVAL, good: if no run is open, run_start = k; run_len++.
  - SC_EVAL, bad: close any open run.
  - On close: if run_len > eye_width (strictly greater, so the first longest wins), update eye_start and eye_width.
  - An open run is also closed after the last position.
  - If k < scan_steps-1: increment step, k++, back to SC_SETTLE.
- Centre:
  - target = eye_start + (eye_width >> 1).
  - Issue (scan_steps-1 - target) decrement steps (CT_EN/CT_WAIT); zero steps is allowed.
  - Then scan_ok = 1 and pulse scan_done.
- No eye (eye_width = 0) or scan_steps = 0: scan_ok = 0, no centring, pulse scan_done. With scan_steps = 0 no sampling takes place.
- psincdec is held at its last value when idle.
- States (one-hot): IDLE, ARM, MAN_EN, MAN_WAIT, SC_SETTLE, SC_SAMPLE, SC_EVAL, SC_EN, SC_WAIT, CT_EN, CT_WAIT, FIN.

Decomposition:
- Package ps_ctrl_pkg: state enum and default PATTERN/TIMEOUT constants.
- One sub-module, ps_step_unit: the EN/WAIT/timeout handshake with the MMCM. It takes a go pulse and direction and returns a done or timeout pulse. Manual, scan and centre phases all reuse it.

Test Plan:
- Manual: psstep = 5, psdir = 1 -> exactly 5 psen pulses (each followed by psdone 3 cycles later), psincdec = 1, phase_pos = 5, one scan_done pulse.
- Auto eye: scan_steps = 64, model returns PATTERN only at positions 10..29 -> eye_start = 10, eye_width = 20, 63 inc steps then 43 dec steps, phase_pos = 20, scan_ok = 1.
- Tie and edge runs: good at 0..4 and 50..54 of 64 -> eye_start = 0, eye_width = 5. Good at 60..63 only -> eye_start = 60, eye_width = 4, 1 dec step, final phase_pos = 62.
- No eye: pattern never matches, scan_steps = 16 -> 15 steps, no centring, scan_ok = 0, scan_done pulses.
- Timeout: psdone withheld -> after 1024 cycles ps_timeout = 1, psen stays 0, return to IDLE. The next pscmd clears ps_timeout.
- Reset mid-scan at k = 7 -> psen = 0, all outputs 0, IDLE on the next cycle. A pscmd pulse held high 3 cycles launches only after it falls.

Source files
------------

// File: rtl/ps_ctrl_pkg.sv
// Shared constants for the MMCM phase-shift / eye-scan controller.
// States are one-hot so a corrupted state vector falls back to IDLE.
package ps_ctrl_pkg;

    typedef logic [11:0] state_t;

    localparam state_t ST_IDLE      = 12'h001;
    localparam state_t ST_ARM       = 12'h002;
    localparam state_t ST_MAN_EN    = 12'h004;
    localparam state_t ST_MAN_WAIT  = 12'h008;
    localparam state_t ST_SC_SETTLE = 12'h010;
    localparam state_t ST_SC_SAMPLE = 12'h020;
    localparam state_t ST_SC_EVAL   = 12'h040;
    localparam state_t ST_SC_EN     = 12'h080;
    localparam state_t ST_SC_WAIT   = 12'h100;
    localparam state_t ST_CT_EN     = 12'h200;
    localparam state_t ST_CT_WAIT   = 12'h400;
    localparam state_t ST_FIN       = 12'h800;

    localparam logic [15:0] DEF_PATTERN     = 16'hBC50;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/ps_eye_scan_ctrl_if.sv
// MMCM dynamic phase-shift port: the controller is master, the MMCM is slave.
interface ps_eye_scan_ctrl_if;

    logic psen;
    logic psincdec;
    logic psdone;

    modport master (output psen, output psincdec, input psdone);
    modport slave  (input psen, input psincdec, output psdone);

endinterface

// File: rtl/ps_step_unit.sv
// One MMCM phase step: a single-cycle psen pulse, then wait for psdone or time out.
// done_o / timeout_o are one-cycle pulses; psdone while not busy is ignored.
module ps_step_unit
    import ps_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic psclk,
    input  logic reset,
    input  logic go_i,
    input  logic dir_i,
    input  logic psdone_i,
    output logic psen_o,
    output logic psincdec_o,
    output logic done_o,
    output logic timeout_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic          psen_q, psen_d;
    logic          psincdec_q, psincdec_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;

    // Next-state for the handshake; the timer starts in the psen cycle.
    always_comb begin
        psen_d     = go_i;
        psincdec_d = go_i ? dir_i : psincdec_q;
        busy_d     = busy_q;
        timer_d    = timer_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        if (go_i) begin
            busy_d  = 1'b1;
            timer_d = '0;
        end else if (busy_q) begin
            if (psdone_i) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else if (timer_q == TIMER_LAST) begin
                busy_d    = 1'b0;
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Handshake registers.
    always_ff @(posedge psclk) begin
        if (reset) begin
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            busy_q     <= 1'b0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            psen_q     <= psen_d;
            psincdec_q <= psincdec_d;
            busy_q     <= busy_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign psen_o     = psen_q;
    assign psincdec_o = psincdec_q;
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;

endmodule

// File: rtl/ps_eye_scan_ctrl.sv
// MMCM dynamic phase-shift controller: manual N-step moves and an automatic
// eye scan that finds the widest good window and returns to its centre.
module ps_eye_scan_ctrl
    import ps_ctrl_pkg::*;
#(
    parameter int unsigned       DW          = 16,
    parameter logic [DW-1:0]     PATTERN     = DW'(DEF_PATTERN),
    parameter int unsigned       STEP_W      = 16,
    parameter int unsigned       SETTLE_CYC  = 8,
    parameter int unsigned       SAMPLES     = 4,
    parameter int unsigned       TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                psclk,
    input  logic                reset,
    input  logic                pscmd,
    input  logic                psmode,
    input  logic                psdir,
    input  logic [STEP_W-1:0]   psstep,
    input  logic [STEP_W-1:0]   scan_steps,
    ps_eye_scan_ctrl_if.master  mmcm,
    input  logic [DW-1:0]       deser_dout,
    output logic                psscan_flag,
    output logic                scan_done,
    output logic                scan_ok,
    output logic                ps_timeout,
    output logic [STEP_W-1:0]   phase_pos,
    output logic [STEP_W-1:0]   eye_start,
    output logic [STEP_W-1:0]   eye_width
);

    localparam logic [STEP_W-1:0] ONE_STEP    = STEP_W'(1);
    localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0]       SAMPLE_LAST = 16'(SAMPLES - 1);

    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   step_rem_q, step_rem_d;
    logic [STEP_W-1:0]   scan_last_q, scan_last_d;
    logic [STEP_W-1:0]   k_q, k_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                good_q, good_d;
    logic                run_open_q, run_open_d;
    logic [STEP_W-1:0]   run_start_q, run_start_d;
    logic [STEP_W-1:0]   run_len_q, run_len_d;
    logic [STEP_W-1:0]   eye_start_q, eye_start_d;
    logic [STEP_W-1:0]   eye_width_q, eye_width_d;
    logic [STEP_W-1:0]   phase_pos_q, phase_pos_d;
    logic                scan_ok_q, scan_ok_d;
    logic                timeout_q, timeout_d;
    logic                scan_done_q, scan_done_d;
    logic                busy_q, busy_d;

    logic                go_s, step_dir_s, step_done_s, step_to_s;
    logic                psen_s, psincdec_s;
    logic                run_open_s, close_s;
    logic [STEP_W-1:0]   run_start_s, run_len_s, eye_start_s, eye_width_s, target_s;

    ps_step_unit #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_step (
        .psclk      (psclk),
        .reset      (reset),
        .go_i       (go_s),
        .dir_i      (step_dir_s),
        .psdone_i   (mmcm.psdone),
        .psen_o     (psen_s),
        .psincdec_o (psincdec_s),
        .done_o     (step_done_s),
        .timeout_o  (step_to_s)
    );

    assign mmcm.psen     = psen_s;
    assign mmcm.psincdec = psincdec_s;

    // Run tracking for the current position; the last position also closes an open run.
    always_comb begin
        run_open_s  = run_open_q;
        run_start_s = run_start_q;
        run_len_s   = run_len_q;
        close_s     = 1'b0;
        if (good_q) begin
            if (!run_open_q) begin
                run_open_s  = 1'b1;
                run_start_s = k_q;
                run_len_s   = '0;
            end else begin
                run_open_s  = 1'b1;
            end
            run_len_s = run_len_s + ONE_STEP;
        end else begin
            close_s = run_open_q;
        end
        if (k_q == scan_last_q) begin
            close_s = run_open_s;
        end else begin
            close_s = close_s;
        end
        eye_start_s = eye_start_q;
        eye_width_s = eye_width_q;
        if (close_s && (run_len_s > eye_width_q)) begin
            eye_start_s = run_start_s;
            eye_width_s = run_len_s;
        end else begin
            eye_width_s = eye_width_q;
        end
        if (close_s) begin
            run_open_s = 1'b0;
            run_len_s  = '0;
        end else begin
            run_open_s = run_open_s;
        end
        target_s = eye_start_s + (eye_width_s >> 1);
    end

    // Main sequencer.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        step_rem_d  = step_rem_q;
        scan_last_d = scan_last_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        good_d      = good_q;
        run_open_d  = run_open_q;
        run_start_d = run_start_q;
        run_len_d   = run_len_q;
        eye_start_d = eye_start_q;
        eye_width_d = eye_width_q;
        phase_pos_d = phase_pos_q;
        scan_ok_d   = scan_ok_q;
        timeout_d   = timeout_q;
        scan_done_d = 1'b0;
        go_s        = 1'b0;
        step_dir_s  = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (pscmd) state_d = ST_ARM;
                else       state_d = ST_IDLE;
            end
            ST_ARM: begin
                if (!pscmd) begin
                    dir_d       = psdir;
                    step_rem_d  = psstep;
                    scan_last_d = scan_steps - ONE_STEP;
                    timeout_d   = 1'b0;
                    if (psmode) begin
                        phase_pos_d = '0;
                        eye_start_d = '0;
                        eye_width_d = '0;
                        run_open_d  = 1'b0;
                        run_start_d = '0;
                        run_len_d   = '0;
                        scan_ok_d   = 1'b0;
                        k_d         = '0;
                        cnt_d       = 16'd0;
                        if (scan_steps == '0) begin
                            state_d     = ST_FIN;
                            scan_done_d = 1'b1;
                        end else begin
                            state_d = ST_SC_SETTLE;
                        end
                    end else begin
                        state_d = ST_MAN_EN;
                    end
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_MAN_EN: begin
                if (step_rem_q == '0) begin
                    state_d     = ST_FIN;
                    scan_done_d = 1'b1;
                end else begin
                    go_s        = 1'b1;
                    phase_pos_d = dir_q ? phase_pos_q + ONE_STEP : phase_pos_q - ONE_STEP;
                    step_rem_d  = step_rem_q - ONE_STEP;
                    state_d     = ST_MAN_WAIT;
                end
            end
            ST_MAN_WAIT, ST_SC_WAIT, ST_CT_WAIT: begin
                if (step_done_s) begin
                    cnt_d = 16'd0;
                    if (state_q == ST_MAN_WAIT)     state_d = ST_MAN_EN;
                    else if (state_q == ST_SC_WAIT) state_d = ST_SC_SETTLE;
                    else                            state_d = ST_CT_EN;
                end else if (step_to_s) begin
                    timeout_d   = 1'b1;
                    scan_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SC_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_SC_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SC_SAMPLE: begin
                if (deser_dout != PATTERN) begin
                    good_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = ST_SC_EVAL;
                end else if (cnt_q == SAMPLE_LAST) begin
                    good_d  = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_SC_EVAL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SC_EVAL: begin
                run_open_d  = run_open_s;
                run_start_d = run_start_s;
                run_len_d   = run_len_s;
                eye_start_d = eye_start_s;
                eye_width_d = eye_width_s;
                if (k_q != scan_last_q) begin
                    state_d = ST_SC_EN;
                end else if (eye_width_s == '0) begin
                    scan_ok_d   = 1'b0;
                    scan_done_d = 1'b1;
                    state_d     = ST_FIN;
                end else begin
                    step_rem_d = scan_last_q - target_s;
                    state_d    = ST_CT_EN;
                end
            end
            ST_SC_EN: begin
                go_s        = 1'b1;
                step_dir_s  = 1'b1;
                phase_pos_d = phase_pos_q + ONE_STEP;
                k_d         = k_q + ONE_STEP;
                state_d     = ST_SC_WAIT;
            end
            ST_CT_EN: begin
                if (step_rem_q == '0) begin
                    scan_ok_d   = 1'b1;
                    scan_done_d = 1'b1;
                    state_d     = ST_FIN;
                end else begin
                    go_s        = 1'b1;
                    step_dir_s  = 1'b0;
                    phase_pos_d = phase_pos_q - ONE_STEP;
                    step_rem_d  = step_rem_q - ONE_STEP;
                    state_d     = ST_CT_WAIT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer registers; reset aborts any move in progress.
    always_ff @(posedge psclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            step_rem_q  <= '0;
            scan_last_q <= '0;
            k_q         <= '0;
            cnt_q       <= 16'd0;
            good_q      <= 1'b0;
            run_open_q  <= 1'b0;
            run_start_q <= '0;
            run_len_q   <= '0;
            eye_start_q <= '0;
            eye_width_q <= '0;
            phase_pos_q <= '0;
            scan_ok_q   <= 1'b0;
            timeout_q   <= 1'b0;
            scan_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            step_rem_q  <= step_rem_d;
            scan_last_q <= scan_last_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            run_open_q  <= run_open_d;
            run_start_q <= run_start_d;
            run_len_q   <= run_len_d;
            eye_start_q <= eye_start_d;
            eye_width_q <= eye_width_d;
            phase_pos_q <= phase_pos_d;
            scan_ok_q   <= scan_ok_d;
            timeout_q   <= timeout_d;
            scan_done_q <= scan_done_d;
            busy_q      <= busy_d;
        end
    end

    assign psscan_flag = busy_q;
    assign scan_done   = scan_done_q;
    assign scan_ok     = scan_ok_q;
    assign ps_timeout  = timeout_q;
    assign phase_pos   = phase_pos_q;
    assign eye_start   = eye_start_q;
    assign eye_width   = eye_width_q;

endmodule

// File: tb/tb_ps_eye_scan_ctrl.sv
// Directed bench for ps_eye_scan_ctrl with an MMCM/deserialiser model and a
// scoreboard of expected end-of-command results.
module tb_ps_eye_scan_ctrl;

    localparam logic [15:0] PAT = 16'hBC50;

    typedef struct {
        logic [15:0] phase;
        logic [15:0] start;
        logic [15:0] width;
        logic        ok;
        logic        to;
        int          npsen;
        int          ninc;
        int          ndec;
    } exp_t;

    logic        psclk = 1'b0;
    logic        reset, pscmd, psmode, psdir;
    logic [15:0] psstep, scan_steps, deser_dout, phase_pos, eye_start, eye_width;
    logic        psscan_flag, scan_done, scan_ok, ps_timeout;

    int psen_cnt = 0, inc_cnt = 0, dec_cnt = 0, sd_cnt = 0, dly = 0;
    int pos_ofs = 0, lo0 = 1, hi0 = 0, lo1 = 1, hi1 = 0;
    logic withhold = 1'b0;
    int nvec = 0, nfail = 0;
    exp_t sb[$];

    ps_eye_scan_ctrl_if mmcm_if ();

    ps_eye_scan_ctrl dut (
        .psclk       (psclk),
        .reset       (reset),
        .pscmd       (pscmd),
        .psmode      (psmode),
        .psdir       (psdir),
        .psstep      (psstep),
        .scan_steps  (scan_steps),
        .mmcm        (mmcm_if.master),
        .deser_dout  (deser_dout),
        .psscan_flag (psscan_flag),
        .scan_done   (scan_done),
        .scan_ok     (scan_ok),
        .ps_timeout  (ps_timeout),
        .phase_pos   (phase_pos),
        .eye_start   (eye_start),
        .eye_width   (eye_width)
    );

    always #5 psclk = ~psclk;

    function automatic logic in_eye(int p, int a0, int b0, int a1, int b1);
        return ((p >= a0) && (p <= b0)) || ((p >= a1) && (p <= b1));
    endfunction

    assign deser_dout = in_eye(inc_cnt - dec_cnt - pos_ofs, lo0, hi0, lo1, hi1) ? PAT : ~PAT;

    // MMCM model: psdone three cycles after each psen unless withheld.
    always @(negedge psclk) begin
        if (reset) begin
            dly            <= 0;
            mmcm_if.psdone <= 1'b0;
        end else begin
            if (mmcm_if.psen) begin
                psen_cnt <= psen_cnt + 1;
                if (mmcm_if.psincdec) inc_cnt <= inc_cnt + 1;
                else                  dec_cnt <= dec_cnt + 1;
                dly            <= withhold ? 0 : 3;
                mmcm_if.psdone <= 1'b0;
            end else if (dly > 0) begin
                dly            <= dly - 1;
                mmcm_if.psdone <= (dly == 2);
            end else begin
                mmcm_if.psdone <= 1'b0;
            end
        end
        if (scan_done) sd_cnt <= sd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(logic [15:0] ph, logic [15:0] st, logic [15:0] wd,
                                logic ok, logic to, int np, int ni, int nd);
        exp_t e;
        e.phase = ph; e.start = st; e.width = wd; e.ok = ok; e.to = to;
        e.npsen = np; e.ninc = ni; e.ndec = nd;
        return e;
    endfunction

    task automatic run_cmd(input string tag, input logic mode, input logic dir,
                           input logic [15:0] step, input logic [15:0] steps,
                           input int hold, input int budget, input exp_t e);
        int p0, i0, d0, s0;
        exp_t r;
        sb.push_back(e);
        p0 = psen_cnt; i0 = inc_cnt; d0 = dec_cnt; s0 = sd_cnt;
        if (mode) pos_ofs = inc_cnt - dec_cnt;
        psmode = mode; psdir = dir; psstep = step; scan_steps = steps;
        pscmd = 1'b1;
        repeat (hold) @(posedge psclk);
        #1;
        if (hold > 1) begin
            check({tag, "_armed_busy"}, {31'd0, psscan_flag}, 32'd1);
            check({tag, "_armed_no_psen"}, psen_cnt - p0, 32'd0);
        end
        pscmd = 1'b0;
        for (int c = 0; c < budget && sd_cnt == s0; c++) @(posedge psclk);
        if (sd_cnt == s0) check({tag, "_done_wait_expired"}, 32'd0, 32'd1);
        repeat (3) @(posedge psclk);
        #1;
        r = sb.pop_front();
        check({tag, "_scan_done_pulses"}, sd_cnt - s0, 32'd1);
        check({tag, "_idle"},       {31'd0, psscan_flag}, 32'd0);
        check({tag, "_phase_pos"},  {16'd0, phase_pos}, {16'd0, r.phase});
        check({tag, "_eye_start"},  {16'd0, eye_start}, {16'd0, r.start});
        check({tag, "_eye_width"},  {16'd0, eye_width}, {16'd0, r.width});
        check({tag, "_scan_ok"},    {31'd0, scan_ok},    {31'd0, r.ok});
        check({tag, "_ps_timeout"}, {31'd0, ps_timeout}, {31'd0, r.to});
        check({tag, "_psen_count"}, psen_cnt - p0, r.npsen);
        check({tag, "_inc_count"},  inc_cnt - i0,  r.ninc);
        check({tag, "_dec_count"},  dec_cnt - d0,  r.ndec);
    endtask

    initial begin
        int i0;
        reset = 1'b1; pscmd = 1'b0; psmode = 1'b0; psdir = 1'b0;
        psstep = 16'd0; scan_steps = 16'd0;
        repeat (3) @(posedge psclk);
        #1 reset = 1'b0;
        @(posedge psclk); #1;
        check("rst_psen",      {31'd0, mmcm_if.psen}, 32'd0);
        check("rst_busy",      {31'd0, psscan_flag}, 32'd0);
        check("rst_scan_done", {31'd0, scan_done}, 32'd0);
        check("rst_scan_ok",   {31'd0, scan_ok}, 32'd0);
        check("rst_timeout",   {31'd0, ps_timeout}, 32'd0);
        check("rst_phase",     {16'd0, phase_pos}, 32'd0);
        check("rst_eye",       {eye_start, eye_width}, 32'd0);

        run_cmd("man_inc5", 1'b0, 1'b1, 16'd5, 16'd0, 1, 400, mk(16'd5, 16'd0, 16'd0, 1'b0, 1'b0, 5, 5, 0));
        check("man_inc5_psincdec", {31'd0, mmcm_if.psincdec}, 32'd1);

        lo0 = 10; hi0 = 29; lo1 = 1; hi1 = 0;
        run_cmd("eye_10_29", 1'b1, 1'b0, 16'd0, 16'd64, 1, 5000, mk(16'd20, 16'd10, 16'd20, 1'b1, 1'b0, 106, 63, 43));

        lo0 = 0; hi0 = 4; lo1 = 50; hi1 = 54;
        run_cmd("eye_tie", 1'b1, 1'b0, 16'd0, 16'd64, 1, 5000, mk(16'd2, 16'd0, 16'd5, 1'b1, 1'b0, 124, 63, 61));

        lo0 = 60; hi0 = 63; lo1 = 1; hi1 = 0;
        run_cmd("eye_edge", 1'b1, 1'b0, 16'd0, 16'd64, 1, 5000, mk(16'd62, 16'd60, 16'd4, 1'b1, 1'b0, 64, 63, 1));

        lo0 = 1; hi0 = 0;
        run_cmd("no_eye", 1'b1, 1'b0, 16'd0, 16'd16, 1, 2000, mk(16'd15, 16'd0, 16'd0, 1'b0, 1'b0, 15, 15, 0));
        run_cmd("scan_zero", 1'b1, 1'b0, 16'd0, 16'd0, 1, 100, mk(16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 0, 0, 0));
        run_cmd("man_zero", 1'b0, 1'b1, 16'd0, 16'd0, 1, 100, mk(16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 0, 0, 0));
        run_cmd("man_dec3", 1'b0, 1'b0, 16'd3, 16'd0, 1, 400, mk(16'hFFFD, 16'd0, 16'd0, 1'b0, 1'b0, 3, 0, 3));
        check("man_dec3_psincdec", {31'd0, mmcm_if.psincdec}, 32'd0);

        withhold = 1'b1;
        run_cmd("timeout", 1'b0, 1'b1, 16'd2, 16'd0, 1, 3000, mk(16'hFFFE, 16'd0, 16'd0, 1'b0, 1'b1, 1, 1, 0));
        check("timeout_psen_low", {31'd0, mmcm_if.psen}, 32'd0);
        withhold = 1'b0;
        run_cmd("to_clear", 1'b0, 1'b1, 16'd0, 16'd0, 1, 100, mk(16'hFFFE, 16'd0, 16'd0, 1'b0, 1'b0, 0, 0, 0));

        // Abort an auto scan at position 7, then launch a command with a long pscmd.
        lo0 = 10; hi0 = 29;
        pos_ofs = inc_cnt - dec_cnt;
        i0 = inc_cnt;
        psmode = 1'b1; scan_steps = 16'd64; pscmd = 1'b1;
        @(posedge psclk); #1 pscmd = 1'b0;
        for (int c = 0; c < 2000 && (inc_cnt - i0) < 7; c++) @(posedge psclk);
        check("midscan_reached_k7", inc_cnt - i0, 32'd7);
        repeat (4) @(posedge psclk);
        #1 reset = 1'b1;
        @(posedge psclk); #1 reset = 1'b0;
        check("abort_psen",    {31'd0, mmcm_if.psen}, 32'd0);
        check("abort_busy",    {31'd0, psscan_flag}, 32'd0);
        check("abort_phase",   {16'd0, phase_pos}, 32'd0);
        check("abort_eye",     {eye_start, eye_width}, 32'd0);
        check("abort_flags",   {29'd0, scan_done, scan_ok, ps_timeout}, 32'd0);
        run_cmd("held_cmd", 1'b0, 1'b1, 16'd3, 16'd0, 3, 400, mk(16'd3, 16'd0, 16'd0, 1'b0, 1'b0, 3, 3, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
